xlate_arbiter: RTL

- Shares one address-translation unit (cache + CAM translate path) among NREQ requesters.
- Accepts translate (TL) and load-CAM-from-cache (LC2C) requests and grants them round-robin.
- Drives the unit's cmd/datain/PID interface and tracks its busy/outvalid/pagefault handshake.
- Returns a tagged response to the granted requester, with a timeout guard against a hung unit.

---
 rtl/xlate_pkg.sv | 25 ++
 rtl/xlate_arbiter_if.sv | 22 ++
 rtl/xlate_arbiter_rr.sv | 30 +++
 rtl/xlate_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/xlate_pkg.sv
// Shared command encodings, FSM states and defaults for the translation-unit arbiter.
package xlate_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_WC   = 2'b01,
        CMD_LC2C = 2'b10,
        CMD_TL   = 2'b11
    } xcmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int unsigned XARB_TIMEOUT_DEF = 64;

    function automatic logic cmd_legal(input logic [1:0] cmd);
        return (cmd == CMD_LC2C) || (cmd == CMD_TL);
    endfunction

endpackage

// File: rtl/xlate_arbiter_if.sv
// Command/response handshake between the arbiter (master) and the translation unit (slave).
interface xlate_arbiter_if;

    logic [1:0] x_cmd;
    logic [7:0] x_datain;
    logic [3:0] x_pid;
    logic       x_busy;
    logic       x_outvalid;
    logic [7:0] x_dataout;
    logic       x_pagefault;

    modport master (
        output x_cmd, x_datain, x_pid,
        input  x_busy, x_outvalid, x_dataout, x_pagefault
    );

    modport slave (
        input  x_cmd, x_datain, x_pid,
        output x_busy, x_outvalid, x_dataout, x_pagefault
    );

endinterface

// File: rtl/xlate_arbiter_rr.sv
// Combinational round-robin pick: scans from ptr+1 with wrap-around, first active request wins.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gid,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/xlate_arbiter.sv
// Round-robin arbiter sharing one address-translation unit among NREQ requesters.
// Optional last-translation bypass register enabled by defining XARB_BYPASS_EN.
module xlate_arbiter
    import xlate_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = XARB_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_cmd,
    input  logic [8*NREQ-1:0]   req_va,
    input  logic [4*NREQ-1:0]   req_pid,
    output logic [NREQ-1:0]     req_ack,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_data,
    output logic                rsp_fault,
    output logic                rsp_timeout,
    xlate_arbiter_if.master     xu
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, id_q, gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic            gnt_any;
    logic [1:0]      cmd_q, sel_cmd;
    logic [7:0]      va_q, sel_va;
    logic [3:0]      pid_q, sel_pid;
    logic [7:0]      timer_q;
    logic            tmo_hit, to_set;
    logic            cap_valid_q, pf_q, to_q, ill_q;
    logic [7:0]      cap_data_q;
    logic            byp_hit, byp_serve;
    logic [7:0]      byp_pa;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (gnt_oh),
        .gid   (gnt_id),
        .any   (gnt_any)
    );

    always_comb begin
        sel_cmd = '0;
        sel_va  = '0;
        sel_pid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_cmd = req_cmd[2*i +: 2];
                sel_va  = req_va[8*i +: 8];
                sel_pid = req_pid[4*i +: 4];
            end
        end
    end

    assign tmo_hit     = (timer_q == 8'(TIMEOUT - 1));
    assign xu.x_datain = va_q;
    assign xu.x_pid    = pid_q;

`ifdef XARB_BYPASS_EN
    logic       byp_valid_q, byp_hit_q;
    logic [3:0] byp_pid_q;
    logic [7:0] byp_va_q, byp_pa_q;

    assign byp_hit   = byp_valid_q && (sel_cmd == CMD_TL) &&
                       (byp_pid_q == sel_pid) && (byp_va_q == sel_va);
    assign byp_serve = byp_hit_q;
    assign byp_pa    = byp_pa_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_valid_q <= 1'b0;
            byp_hit_q   <= 1'b0;
            byp_pid_q   <= '0;
            byp_va_q    <= '0;
            byp_pa_q    <= '0;
        end else if (state_q == ST_ARB && gnt_any) begin
            byp_hit_q <= byp_hit;
            if (sel_cmd == CMD_LC2C && byp_pid_q == sel_pid)
                byp_valid_q <= 1'b0;
        end else if (state_q == ST_RESP && cmd_q == CMD_TL && !rsp_fault &&
                     (cap_valid_q || byp_hit_q)) begin
            byp_valid_q <= 1'b1;
            byp_pid_q   <= pid_q;
            byp_va_q    <= va_q;
            byp_pa_q    <= rsp_data;
        end
    end
`else
    assign byp_hit   = 1'b0;
    assign byp_serve = 1'b0;
    assign byp_pa    = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        xu.x_cmd    = CMD_NOP;
        to_set      = 1'b0;
        req_ack     = '0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_data    = '0;
        rsp_fault   = 1'b0;
        rsp_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req && !xu.x_busy) state_d = ST_ARB;
            end
            ST_ARB: begin
                // A request dropped between IDLE and ARB leaves nothing to grant.
                if (!gnt_any)                          state_d = ST_IDLE;
                else if (!cmd_legal(sel_cmd) || byp_hit) state_d = ST_RESP;
                else                                   state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tmo_hit) begin
                    state_d = ST_RESP;
                    to_set  = 1'b1;
                end else begin
                    xu.x_cmd = cmd_q;
                    if (xu.x_busy) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!xu.x_busy) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    to_set  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                rsp_valid    = 1'b1;
                req_ack[id_q] = 1'b1;
                rsp_id       = id_q;
                rsp_timeout  = to_q;
                // Unit page faults only matter for translations; LC2C reports none.
                rsp_fault    = to_q | ill_q | (pf_q & (cmd_q == CMD_TL));
                if (byp_serve)
                    rsp_data = byp_pa;
                else if (cmd_q == CMD_TL && cap_valid_q && !pf_q && !to_q)
                    rsp_data = cap_data_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            cmd_q       <= '0;
            va_q        <= '0;
            pid_q       <= '0;
            timer_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            pf_q        <= 1'b0;
            to_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (gnt_any) begin
                        ptr_q       <= gnt_id;
                        id_q        <= gnt_id;
                        cmd_q       <= sel_cmd;
                        va_q        <= sel_va;
                        pid_q       <= sel_pid;
                        timer_q     <= '0;
                        cap_valid_q <= 1'b0;
                        cap_data_q  <= '0;
                        pf_q        <= 1'b0;
                        to_q        <= 1'b0;
                        ill_q       <= !cmd_legal(sel_cmd);
                    end
                end
                ST_ISSUE: begin
                    timer_q <= timer_q + 8'd1;
                    if (to_set) to_q <= 1'b1;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (to_set) to_q <= 1'b1;
                    if (xu.x_outvalid) begin
                        cap_valid_q <= 1'b1;
                        cap_data_q  <= xu.x_dataout;
                    end
                    if (xu.x_pagefault) pf_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
